rv_0_ahb_sram_slave: RTL and testbench

RV_0_AHB_SRAM_SLAVE -- requirements
Module: rv_0_ahb_sram_slave

---
 rtl/rv_0_ahb_pkg.sv | 29 ++
 rtl/rv_0_sram_sp32.sv | 38 +++
 rtl/rv_0_ahb_sram_slave.sv | 139 +++++++++++++
 tb/tb_rv_0_ahb_sram_slave.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_0_ahb_pkg.sv
// rv_0_ahb_pkg
//   Shared AHB-Lite encodings (HTRANS, HSIZE, HRESP) and the state type of
//   the SRAM slave controller. No ports; imported by the slave and its array.
package rv_0_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   // Controller state. A plain vector type keeps the encoding visible to
   // legacy code and to any checker that probes the state register.
   typedef logic [2:0] ahb_state_t;

   localparam ahb_state_t ST_IDLE  = 3'd0;
   localparam ahb_state_t ST_WDATA = 3'd1;
   localparam ahb_state_t ST_RWAIT = 3'd2;
   localparam ahb_state_t ST_RDATA = 3'd3;
   localparam ahb_state_t ST_ERR1  = 3'd4;
   localparam ahb_state_t ST_ERR2  = 3'd5;

endpackage

// File: rtl/rv_0_sram_sp32.sv
// rv_0_sram_sp32
//   Single-port synchronous 32-bit SRAM, 2^AW words, per-byte write enables.
//   Ports:
//     cpu_clk  in   clock, rising edge
//     ce       in   port enable for this cycle
//     we[3:0]  in   byte write enables; all zero with ce=1 is a read
//     addr     in   word address
//     wdata    in   write data (byte lanes follow we)
//     rdata    out  registered read data, updated only by a read access
//   Contents are not reset.
module rv_0_sram_sp32
   import rv_0_ahb_pkg::*;
#(
   parameter int AW = 14
) (
   input  logic          cpu_clk,
   input  logic          ce,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [0:(2**AW)-1];

   always_ff @(posedge cpu_clk) begin
      if (ce) begin
         if (|we) begin
            for (int b = 0; b < 4; b++) begin
               if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/rv_0_ahb_sram_slave.sv
// rv_0_ahb_sram_slave
//   AHB-Lite slave fronting a 2^AW x 32 single-port SRAM at BASE_ADDR, with
//   RD_WAIT wait states on reads and a two-cycle ERROR response for
//   out-of-window or misaligned transfers.
//   Ports:
//     cpu_clk, pad_cpu_rst_b   clock, async active-low reset
//     haddr/htrans/hwrite/hsize/hburst/hprot/hwdata   AHB-Lite master inputs
//     hrdata, hready, hresp                           AHB-Lite slave outputs
//   Handshake: an address phase is taken on a rising edge where hready=1 and
//   htrans[1]=1; its data phase completes on the first later edge with
//   hready=1. Anything presented while hready=0 is not sampled.
module rv_0_ahb_sram_slave
   import rv_0_ahb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
   parameter int          AW        = 14,
   parameter int          RD_WAIT   = 1
) (
   input  logic        cpu_clk,
   input  logic        pad_cpu_rst_b,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [3:0]  hprot,
   input  logic [31:0] hwdata,
   output logic [31:0] hrdata,
   output logic        hready,
   output logic [1:0]  hresp
);

   // RWAIT counts down from this value; with RD_WAIT=0 RWAIT is only used
   // for the single extra cycle when a read follows a write on the one port.
   localparam logic [1:0] WAIT_LOAD = (RD_WAIT > 0) ? 2'(RD_WAIT - 1) : 2'd0;

   ahb_state_t    state_q, state_d;
   logic [AW+1:0] addr_q;
   logic [2:0]    size_q;
   logic          write_q;
   logic [1:0]    wait_q;
   logic [31:0]   hrdata_q;

   logic          accept;
   logic          addr_err;
   logic [3:0]    be;
   logic          wr_now, rd_direct, rd_wait_done;
   logic          sram_ce;
   logic [3:0]    sram_we;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_rdata;

   logic unused_inputs;
   assign unused_inputs = ^{hburst, hprot, htrans[0]};

   assign hready = !((state_q == ST_RWAIT) || (state_q == ST_ERR1));
   assign hresp  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   assign accept = hready && htrans[1];

   always_comb begin
      addr_err = 1'b0;
      if (haddr[31:AW+2] != BASE_ADDR[31:AW+2]) addr_err = 1'b1;
      case (hsize)
         HSIZE_BYTE: ;
         HSIZE_HALF: if (haddr[0]) addr_err = 1'b1;
         HSIZE_WORD: if (haddr[1:0] != 2'b00) addr_err = 1'b1;
         default:    addr_err = 1'b1;
      endcase
   end

   always_comb begin
      be = 4'b1111;
      case (size_q)
         HSIZE_BYTE: be = 4'b0001 << addr_q[1:0];
         HSIZE_HALF: be = addr_q[1] ? 4'b1100 : 4'b0011;
         default:    be = 4'b1111;
      endcase
   end

   // Writes commit at the edge ending WDATA. A zero-wait read issues on the
   // edge that accepts it, unless the port is busy with that commit; other
   // reads issue on the last RWAIT edge, after any preceding write landed,
   // so a read straight after a write sees the merged word.
   assign wr_now       = (state_q == ST_WDATA) && write_q;
   assign rd_direct    = accept && !addr_err && !hwrite && (RD_WAIT == 0) && (state_q != ST_WDATA);
   assign rd_wait_done = (state_q == ST_RWAIT) && (wait_q == 2'd0);
   assign sram_ce      = wr_now || rd_direct || rd_wait_done;
   assign sram_we      = wr_now ? be : 4'b0000;
   assign sram_addr    = rd_direct ? haddr[AW+1:2] : addr_q[AW+1:2];

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RWAIT: if (wait_q == 2'd0) state_d = ST_RDATA;
         ST_ERR1:  state_d = ST_ERR2;
         default: begin
            if (!accept)                                      state_d = ST_IDLE;
            else if (addr_err)                                state_d = ST_ERR1;
            else if (hwrite)                                  state_d = ST_WDATA;
            else if ((RD_WAIT > 0) || (state_q == ST_WDATA))  state_d = ST_RWAIT;
            else                                              state_d = ST_RDATA;
         end
      endcase
   end

   always_ff @(posedge cpu_clk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         size_q   <= '0;
         write_q  <= 1'b0;
         wait_q   <= 2'd0;
         hrdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= haddr[AW+1:0];
            size_q  <= hsize;
            write_q <= hwrite;
         end
         if ((state_d == ST_RWAIT) && (state_q != ST_RWAIT)) wait_q <= WAIT_LOAD;
         else if ((state_q == ST_RWAIT) && (wait_q != 2'd0)) wait_q <= wait_q - 2'd1;
         if (state_q == ST_RDATA) hrdata_q <= sram_rdata;
      end
   end

   // Live array data during RDATA, otherwise the last value delivered.
   assign hrdata = (state_q == ST_RDATA) ? sram_rdata : hrdata_q;

   rv_0_sram_sp32 #(.AW(AW)) u_sram (
      .cpu_clk (cpu_clk),
      .ce      (sram_ce),
      .we      (sram_we),
      .addr    (sram_addr),
      .wdata   (hwdata),
      .rdata   (sram_rdata)
   );

endmodule

// File: tb/tb_rv_0_ahb_sram_slave.sv
module tb_rv_0_ahb_sram_slave;

   localparam logic [31:0] BASE    = 32'h2000_0000;
   localparam int          RD_WAIT = 1;

   logic        cpu_clk = 1'b0;
   logic        pad_cpu_rst_b;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic [1:0]  hresp;

   int vectors     = 0;
   int miscompares = 0;

   // Reference memory: one entry per byte offset inside the window.
   logic [7:0] model_mem [int];

   rv_0_ahb_sram_slave #(.BASE_ADDR(BASE), .AW(14), .RD_WAIT(RD_WAIT)) dut (
      .cpu_clk       (cpu_clk),
      .pad_cpu_rst_b (pad_cpu_rst_b),
      .haddr         (haddr),
      .htrans        (htrans),
      .hwrite        (hwrite),
      .hsize         (hsize),
      .hburst        (hburst),
      .hprot         (hprot),
      .hwdata        (hwdata),
      .hrdata        (hrdata),
      .hready        (hready),
      .hresp         (hresp)
   );

   always #5 cpu_clk = ~cpu_clk;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Byte-level effect of a legal write: the bytes named by size and the low
   // address bits take the matching lanes of the bus word.
   task automatic model_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd);
      int off;
      int lane;
      off = int'(addr - BASE);
      for (int b = 0; b < (1 << size); b++) begin
         lane = (off + b) % 4;
         model_mem[off + b] = wd[8*lane +: 8];
      end
   endtask

   function automatic logic [31:0] model_word(input logic [31:0] addr);
      int base;
      logic [31:0] w;
      base = int'(addr - BASE) & ~3;
      w = 32'hx;
      for (int b = 0; b < 4; b++) begin
         if (model_mem.exists(base + b)) w[8*b +: 8] = model_mem[base + b];
      end
      return w;
   endfunction

   // One isolated transfer; entered and left 1 time unit after a rising edge.
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic [1:0] resp, output logic [1:0] wresp, output int waits);
      haddr  = addr;
      hwrite = wr;
      hsize  = size;
      htrans = 2'b10;
      @(posedge cpu_clk);
      #1;
      htrans = 2'b00;
      hwdata = wd;
      waits  = 0;
      wresp  = 2'b00;
      @(negedge cpu_clk);
      while (!hready && waits < 8) begin
         wresp = hresp;
         waits++;
         @(negedge cpu_clk);
      end
      rd   = hrdata;
      resp = hresp;
      @(posedge cpu_clk);
      #1;
   endtask

   logic [31:0] rd, wd, addr, exp_w;
   logic [1:0]  resp, wresp;
   logic [2:0]  size;
   logic        wr;
   int          waits, r, idx, kind;
   logic [31:0] bb_data [4];

   initial begin
      pad_cpu_rst_b = 1'b0;
      haddr  = 32'd0;
      htrans = 2'b00;
      hwrite = 1'b0;
      hsize  = 3'd0;
      hburst = 3'd0;
      hprot  = 4'b0011;
      hwdata = 32'd0;
      repeat (3) @(posedge cpu_clk);
      @(negedge cpu_clk);
      check("rst_hready", {31'd0, hready}, 32'd1);
      check("rst_hresp", {30'd0, hresp}, 32'd0);
      check("rst_hrdata", hrdata, 32'd0);
      pad_cpu_rst_b = 1'b1;
      @(posedge cpu_clk);
      #1;

      // Word write then read with one wait state.
      xfer(BASE + 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, rd, resp, wresp, waits);
      model_write(BASE + 32'h10, 3'd2, 32'hDEAD_BEEF);
      check("wr_word_waits", 32'(waits), 32'd0);
      xfer(BASE + 32'h10, 1'b0, 3'd2, 32'd0, rd, resp, wresp, waits);
      check("rd_word_waits", 32'(waits), 32'(RD_WAIT));
      check("rd_word_data", rd, 32'hDEAD_BEEF);
      check("rd_word_resp", {30'd0, resp}, 32'd0);
      @(negedge cpu_clk);
      check("hrdata_hold", hrdata, 32'hDEAD_BEEF);
      @(posedge cpu_clk);
      #1;

      // Byte write on lane 3 merges into the word.
      xfer(BASE + 32'h13, 1'b1, 3'd0, 32'h5A00_0000, rd, resp, wresp, waits);
      model_write(BASE + 32'h13, 3'd0, 32'h5A00_0000);
      xfer(BASE + 32'h10, 1'b0, 3'd2, 32'd0, rd, resp, wresp, waits);
      check("rd_byte_merge", rd, 32'h5AAD_BEEF);

      // Out-of-window read: two-cycle ERROR, memory untouched.
      xfer(32'h3000_0000, 1'b0, 3'd2, 32'd0, rd, resp, wresp, waits);
      check("oow_waits", 32'(waits), 32'd1);
      check("oow_resp_wait", {30'd0, wresp}, 32'd1);
      check("oow_resp_final", {30'd0, resp}, 32'd1);
      xfer(32'h3000_0010, 1'b1, 3'd2, 32'h1234_5678, rd, resp, wresp, waits);
      check("oow_wr_resp", {30'd0, resp}, 32'd1);
      xfer(BASE + 32'h10, 1'b0, 3'd2, 32'd0, rd, resp, wresp, waits);
      check("oow_mem_unchanged", rd, 32'h5AAD_BEEF);

      // Misaligned word errors, aligned upper halfword is fine.
      xfer(BASE, 1'b1, 3'd2, 32'hCAFE_1234, rd, resp, wresp, waits);
      model_write(BASE, 3'd2, 32'hCAFE_1234);
      xfer(BASE + 32'h2, 1'b0, 3'd2, 32'd0, rd, resp, wresp, waits);
      check("misal_word_waits", 32'(waits), 32'd1);
      check("misal_word_resp", {30'd0, resp}, 32'd1);
      xfer(BASE + 32'h2, 1'b0, 3'd1, 32'd0, rd, resp, wresp, waits);
      check("half_hi_resp", {30'd0, resp}, 32'd0);
      check("half_hi_data", {16'd0, rd[31:16]}, 32'h0000_CAFE);

      // Write immediately followed by a read of the same word.
      haddr = BASE + 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
      @(posedge cpu_clk);
      #1;
      hwdata = 32'h1;
      haddr  = BASE + 32'h20; hwrite = 1'b0; htrans = 2'b10;
      model_write(BASE + 32'h20, 3'd2, 32'h1);
      @(negedge cpu_clk);
      check("wr_rd_pipe_ready", {31'd0, hready}, 32'd1);
      @(posedge cpu_clk);
      #1;
      htrans = 2'b00;
      waits = 0;
      @(negedge cpu_clk);
      while (!hready && waits < 8) begin
         waits++;
         @(negedge cpu_clk);
      end
      check("wr_rd_pipe_waits", 32'(waits), 32'd1);
      check("wr_rd_pipe_data", hrdata, 32'h1);
      check("wr_rd_pipe_resp", {30'd0, hresp}, 32'd0);
      @(posedge cpu_clk);
      #1;

      // Back-to-back writes, one per cycle.
      for (int k = 0; k < 4; k++) bb_data[k] = $urandom;
      haddr = BASE + 32'h200; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
      for (int k = 0; k < 4; k++) begin
         @(posedge cpu_clk);
         #1;
         hwdata = bb_data[k];
         model_write(BASE + 32'h200 + 32'(4 * k), 3'd2, bb_data[k]);
         if (k < 3) haddr = BASE + 32'h200 + 32'(4 * (k + 1));
         else htrans = 2'b00;
         @(negedge cpu_clk);
         check("b2b_wr_ready", {31'd0, hready}, 32'd1);
      end
      @(posedge cpu_clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         xfer(BASE + 32'h200 + 32'(4 * k), 1'b0, 3'd2, 32'd0, rd, resp, wresp, waits);
         check("b2b_rd_data", rd, bb_data[k]);
      end

      // Reset pulsed while a read is waiting.
      haddr = BASE + 32'h10; hwrite = 1'b0; hsize = 3'd2; htrans = 2'b10;
      @(posedge cpu_clk);
      #1;
      htrans = 2'b00;
      check("rwait_hready", {31'd0, hready}, 32'd0);
      pad_cpu_rst_b = 1'b0;
      #1;
      check("rst_mid_hready", {31'd0, hready}, 32'd1);
      check("rst_mid_hresp", {30'd0, hresp}, 32'd0);
      check("rst_mid_hrdata", hrdata, 32'd0);
      @(negedge cpu_clk);
      pad_cpu_rst_b = 1'b1;
      @(posedge cpu_clk);
      #1;
      check("post_rst_hready", {31'd0, hready}, 32'd1);
      xfer(BASE + 32'h10, 1'b0, 3'd2, 32'd0, rd, resp, wresp, waits);
      check("post_rst_data", rd, 32'h5AAD_BEEF);

      // Random traffic over a pool of 16 words.
      for (int i = 0; i < 16; i++) begin
         wd = $urandom;
         xfer(BASE + 32'h100 + 32'(4 * i), 1'b1, 3'd2, wd, rd, resp, wresp, waits);
         model_write(BASE + 32'h100 + 32'(4 * i), 3'd2, wd);
      end
      for (int i = 0; i < 150; i++) begin
         r   = $urandom_range(0, 9);
         idx = $urandom_range(0, 15);
         addr = BASE + 32'h100 + 32'(4 * idx);
         size = 3'($urandom_range(0, 2));
         if (size == 3'd0) addr = addr + 32'($urandom_range(0, 3));
         else if (size == 3'd1) addr = addr + 32'(2 * $urandom_range(0, 1));
         wd = $urandom;
         if (r < 4) begin
            xfer(addr, 1'b1, size, wd, rd, resp, wresp, waits);
            model_write(addr, size, wd);
            check("rand_wr_waits", 32'(waits), 32'd0);
            check("rand_wr_resp", {30'd0, resp}, 32'd0);
         end else if (r < 8) begin
            exp_w = model_word(addr);
            xfer(addr, 1'b0, size, 32'd0, rd, resp, wresp, waits);
            check("rand_rd_waits", 32'(waits), 32'(RD_WAIT));
            check("rand_rd_resp", {30'd0, resp}, 32'd0);
            check("rand_rd_data", rd, exp_w);
         end else begin
            kind = $urandom_range(0, 3);
            wr = 1'($urandom_range(0, 1));
            case (kind)
               0: begin addr = 32'h2001_0000 + ($urandom & 32'h0000_FFFC); size = 3'd2; end
               1: begin addr = BASE + 32'h100 + 32'(4 * idx) + 32'($urandom_range(1, 3)); size = 3'd2; end
               2: begin addr = BASE + 32'h100 + 32'(4 * idx) + 32'(2 * $urandom_range(0, 1) + 1); size = 3'd1; end
               default: begin addr = BASE + 32'h100 + 32'(4 * idx); size = 3'($urandom_range(3, 7)); end
            endcase
            xfer(addr, wr, size, wd, rd, resp, wresp, waits);
            check("rand_err_waits", 32'(waits), 32'd1);
            check("rand_err_resp1", {30'd0, wresp}, 32'd1);
            check("rand_err_resp2", {30'd0, resp}, 32'd1);
         end
      end

      // Final sweep: every pool word must match the reference.
      for (int i = 0; i < 16; i++) begin
         addr = BASE + 32'h100 + 32'(4 * i);
         exp_w = model_word(addr);
         xfer(addr, 1'b0, 3'd2, 32'd0, rd, resp, wresp, waits);
         check("sweep_data", rd, exp_w);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
